// File: rtl/fft_mag_peak_if.sv
// openMSP430 peripheral bus bundle for fft_mag_peak, plus its completion interrupt.
// The CPU side uses the master modport; the peripheral uses slave.
interface fft_mag_peak_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        irq_done;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout, irq_done
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout, irq_done
    );
endinterface

// File: rtl/fft_mag_peak.sv
// Scans 16 complex FFT bins one per clock, stores saturated L1 magnitudes, tracks the peak,
// and exposes everything as openMSP430 peripheral registers with a one-cycle done interrupt.
module fft_mag_peak #(
    parameter logic [13:0] BASE_ADDR = 14'hA8,
    parameter logic [13:0] MAG_BASE  = 14'hB0
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic [255:0]      bin_re,
    input  logic [255:0]      bin_im,
    fft_mag_peak_if.slave     bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] mag_q [16];
    logic [15:0] mag_d [16];
    logic [15:0] peak_q, peak_d;
    logic [3:0]  peak_idx_q, peak_idx_d;
    logic [15:0] thresh_q, thresh_d;
    logic        done_q, done_d;
    logic        over_q, over_d;
    logic        irq_q, irq_d;

    logic        wr_en, rd_en, ctrl_wr, start, clr;
    logic [15:0] cur_re, cur_im, abs_re, abs_im, mag_sat;
    logic [16:0] mag_sum;
    logic [13:0] mag_off;
    logic [15:0] rd_data;

    always_comb begin
        wr_en   = bus.per_en && (bus.per_we == 2'b11);
        rd_en   = bus.per_en && (bus.per_we == 2'b00);
        ctrl_wr = wr_en && (bus.per_addr == BASE_ADDR);
        start   = ctrl_wr && bus.per_din[0] && (state_q != ST_SCAN);
        clr     = ctrl_wr && bus.per_din[1];

        // Two's-complement negate in 16 bits maps -32768 to 16'h8000, i.e. 32768 unsigned.
        cur_re  = bin_re[{idx_q[3:0], 4'b0000} +: 16];
        cur_im  = bin_im[{idx_q[3:0], 4'b0000} +: 16];
        abs_re  = cur_re[15] ? (~cur_re + 16'd1) : cur_re;
        abs_im  = cur_im[15] ? (~cur_im + 16'd1) : cur_im;
        mag_sum = {1'b0, abs_re} + {1'b0, abs_im};
        mag_sat = mag_sum[16] ? '1 : mag_sum[15:0];

        state_d    = state_q;
        idx_d      = idx_q;
        mag_d      = mag_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        thresh_d   = thresh_q;
        done_d     = done_q;
        over_d     = over_q;
        irq_d      = 1'b0;

        if (wr_en && (bus.per_addr == BASE_ADDR + 14'd3)) begin
            thresh_d = bus.per_din;
        end

        if (clr) begin
            done_d = 1'b0;
            over_d = 1'b0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end

        // idx_q[4] marks the closing cycle that compares the settled peak against THRESH.
        if (state_q == ST_SCAN) begin
            if (idx_q[4]) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                irq_d   = 1'b1;
                over_d  = (peak_q > thresh_q);
            end else begin
                mag_d[idx_q[3:0]] = mag_sat;
                if ((idx_q == 5'd0) || (mag_sat > peak_q)) begin
                    peak_d     = mag_sat;
                    peak_idx_d = idx_q[3:0];
                end
                idx_d = idx_q + 5'd1;
            end
        end

        if (start) begin
            state_d    = ST_SCAN;
            idx_d      = '0;
            done_d     = 1'b0;
            over_d     = 1'b0;
            peak_d     = '0;
            peak_idx_d = '0;
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            for (int unsigned k = 0; k < 16; k++) begin
                mag_q[k] <= '0;
            end
            peak_q     <= '0;
            peak_idx_q <= '0;
            thresh_q   <= '0;
            done_q     <= 1'b0;
            over_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mag_q      <= mag_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            thresh_q   <= thresh_d;
            done_q     <= done_d;
            over_q     <= over_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        mag_off = bus.per_addr - MAG_BASE;
        rd_data = '0;
        if (rd_en) begin
            if (bus.per_addr == BASE_ADDR + 14'd1) begin
                rd_data = {8'h00, peak_idx_q, 1'b0, over_q, done_q, (state_q == ST_SCAN)};
            end else if (bus.per_addr == BASE_ADDR + 14'd2) begin
                rd_data = peak_q;
            end else if (bus.per_addr == BASE_ADDR + 14'd3) begin
                rd_data = thresh_q;
            end else if (mag_off < 14'd16) begin
                rd_data = mag_q[mag_off[3:0]];
            end
        end
    end

    assign bus.per_dout = rd_data;
    assign bus.irq_done = irq_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: register reads, scan timing, saturation, tie-break,
// START/CLR handling and reset during a scan, all against hand-computed values.
module tb_fft_mag_peak;
    localparam logic [13:0] BASE = 14'hA8;
    localparam logic [13:0] MAGB = 14'hB0;

    logic         mclk = 1'b0;
    logic         puc_rst_n = 1'b0;
    logic [255:0] bin_re = '0;
    logic [255:0] bin_im = '0;

    int vectors = 0;
    int miscompares = 0;
    int irq_cyc;
    int irq_cnt;
    logic [15:0] rd;

    fft_mag_peak_if bus ();

    fft_mag_peak #(.BASE_ADDR(14'hA8), .MAG_BASE(14'hB0)) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .bin_re    (bin_re),
        .bin_im    (bin_im),
        .bus       (bus)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] we);
        @(negedge mclk);
        bus.per_addr = addr;
        bus.per_din  = data;
        bus.per_we   = we;
        bus.per_en   = 1'b1;
        @(negedge mclk);
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic bus_read(input logic [13:0] addr, input logic [1:0] we, output logic [15:0] data);
        bus.per_addr = addr;
        bus.per_we   = we;
        bus.per_en   = 1'b1;
        #1;
        data = bus.per_dout;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] addr, input logic [15:0] exp);
        logic [15:0] v;
        bus_read(addr, 2'b00, v);
        chk(tag, {16'h0, v}, {16'h0, exp});
    endtask

    // Called right after the START edge t; cycle c observes just after edge t+c.
    task automatic scan_wait(input int inj_cycle, input logic [15:0] inj_data, input int rst_cycle,
                             output int first_irq, output int n_irq);
        first_irq = -1;
        n_irq = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c == inj_cycle) begin
                bus.per_addr = BASE;
                bus.per_din  = inj_data;
                bus.per_we   = 2'b11;
                bus.per_en   = 1'b1;
            end
            @(posedge mclk);
            #1;
            bus.per_en = 1'b0;
            bus.per_we = 2'b00;
            if (c == rst_cycle) puc_rst_n = 1'b0;
            if (c == rst_cycle + 2) puc_rst_n = 1'b1;
            if (bus.irq_done === 1'b1) begin
                if (first_irq < 0) first_irq = c;
                n_irq++;
            end
        end
    endtask

    task automatic set_bin(input int k, input logic [15:0] re, input logic [15:0] im);
        bin_re[k*16 +: 16] = re;
        bin_im[k*16 +: 16] = im;
    endtask

    initial begin
        bus.per_addr = '0;
        bus.per_din  = '0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;

        // Reset: every register reads zero, no interrupt
        #12;
        chk("rst_irq", {31'h0, bus.irq_done}, 32'h0);
        rd_chk("rst_status_in_reset", BASE + 14'd1, 16'h0000);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        rd_chk("rst_ctrl", BASE, 16'h0000);
        rd_chk("rst_status", BASE + 14'd1, 16'h0000);
        rd_chk("rst_peak", BASE + 14'd2, 16'h0000);
        rd_chk("rst_thresh", BASE + 14'd3, 16'h0000);
        for (int k = 0; k < 16; k++) rd_chk($sformatf("rst_mag%0d", k), MAGB + 14'(k), 16'h0000);

        // All bins 0x0100: equal magnitudes, lowest index wins, irq on cycle 17
        for (int k = 0; k < 16; k++) set_bin(k, 16'h0100, 16'h0000);
        bus_write(BASE, 16'h0001, 2'b11);
        rd_chk("t1_busy", BASE + 14'd1, 16'h0001);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t1_irq_cycle", irq_cyc, 32'd17);
        chk("t1_irq_count", irq_cnt, 32'd1);
        for (int k = 0; k < 16; k++) rd_chk($sformatf("t1_mag%0d", k), MAGB + 14'(k), 16'h0100);
        rd_chk("t1_peak", BASE + 14'd2, 16'h0100);
        rd_chk("t1_status", BASE + 14'd1, 16'h0006);
        rd_chk("t1_unmapped_ac", 14'h0AC, 16'h0000);
        rd_chk("t1_unmapped_c0", MAGB + 14'd16, 16'h0000);
        bus_read(BASE + 14'd2, 2'b10, rd);
        chk("t1_read_we_nonzero", {16'h0, rd}, 32'h0);
        bus_write(BASE, 16'h0002, 2'b11);
        rd_chk("t1_after_clr", BASE + 14'd1, 16'h0000);

        // Bin5 = -3 + 4j, THRESH 6 -> mag 7, over set
        for (int k = 0; k < 16; k++) set_bin(k, 16'h0000, 16'h0000);
        set_bin(5, 16'hFFFD, 16'h0004);
        bus_write(BASE + 14'd3, 16'h0006, 2'b11);
        bus_write(BASE + 14'd3, 16'h1234, 2'b01);
        rd_chk("t2_thresh_partial_ignored", BASE + 14'd3, 16'h0006);
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t2_irq_cycle", irq_cyc, 32'd17);
        for (int k = 0; k < 16; k++)
            rd_chk($sformatf("t2_mag%0d", k), MAGB + 14'(k), (k == 5) ? 16'h0007 : 16'h0000);
        rd_chk("t2_peak", BASE + 14'd2, 16'h0007);
        rd_chk("t2_status", BASE + 14'd1, 16'h0056);

        // Saturation and tie at max: bins 9 and 12 both 0xFFFF, THRESH 0xFFFF (not strictly over)
        set_bin(5, 16'h0000, 16'h0000);
        set_bin(2, 16'h7FFF, 16'h7FFF);
        set_bin(3, 16'h8000, 16'h0000);
        set_bin(9, 16'h8000, 16'h8000);
        set_bin(12, 16'h8000, 16'h8000);
        bus_write(BASE + 14'd3, 16'hFFFF, 2'b11);
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t3_irq_cycle", irq_cyc, 32'd17);
        rd_chk("t3_mag2", MAGB + 14'd2, 16'hFFFE);
        rd_chk("t3_mag3", MAGB + 14'd3, 16'h8000);
        rd_chk("t3_mag9", MAGB + 14'd9, 16'hFFFF);
        rd_chk("t3_mag12", MAGB + 14'd12, 16'hFFFF);
        rd_chk("t3_mag5", MAGB + 14'd5, 16'h0000);
        rd_chk("t3_peak", BASE + 14'd2, 16'hFFFF);
        rd_chk("t3_status", BASE + 14'd1, 16'h0092);

        // START during scan cycle 5 is ignored; completion stays at cycle 17
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(5, 16'h0001, 0, irq_cyc, irq_cnt);
        chk("t4_irq_cycle", irq_cyc, 32'd17);
        chk("t4_irq_count", irq_cnt, 32'd1);
        rd_chk("t4_status", BASE + 14'd1, 16'h0092);
        bus_write(BASE, 16'h0002, 2'b11);
        rd_chk("t4_clr_keeps_idx", BASE + 14'd1, 16'h0090);
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t4_rescan_irq", irq_cyc, 32'd17);
        bus_write(BASE, 16'h0003, 2'b11);
        rd_chk("t4_start_clr_status", BASE + 14'd1, 16'h0001);
        rd_chk("t4_start_clr_peak", BASE + 14'd2, 16'h0000);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t4_start_clr_irq", irq_cyc, 32'd17);
        rd_chk("t4_final_status", BASE + 14'd1, 16'h0092);

        // Reset at scan cycle 8 aborts with no interrupt; a fresh START then completes
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(0, 16'h0, 8, irq_cyc, irq_cnt);
        chk("t5_no_irq", irq_cnt, 32'd0);
        rd_chk("t5_status", BASE + 14'd1, 16'h0000);
        rd_chk("t5_peak", BASE + 14'd2, 16'h0000);
        rd_chk("t5_thresh", BASE + 14'd3, 16'h0000);
        rd_chk("t5_mag2", MAGB + 14'd2, 16'h0000);
        rd_chk("t5_mag9", MAGB + 14'd9, 16'h0000);
        bus_write(BASE, 16'h0001, 2'b11);
        scan_wait(0, 16'h0, 0, irq_cyc, irq_cnt);
        chk("t5_irq_cycle", irq_cyc, 32'd17);
        chk("t5_irq_count", irq_cnt, 32'd1);
        rd_chk("t5_mag9_after", MAGB + 14'd9, 16'hFFFF);
        rd_chk("t5_status_after", BASE + 14'd1, 16'h0096);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
